mdu_e: RTL



---
 rtl/mdu_e.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mdu_e.sv
// mdu_e: E-stage multiply/divide unit.
// Holds the architectural HI/LO registers. MULT/MULTU/DIV/DIVU latch their
// operands on the Start edge and then report Busy for a fixed number of cycles
// before committing to HI/LO. MTHI/MTLO write HI/LO in a single cycle.
//
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   Start    - one-cycle strobe: the E-stage instruction is an MDU operation
//   MDUOp    - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//              110/111 no-op
//   A, B     - forwarded rs / rt operands
//   Busy     - high while a MULT/DIV is in flight (registered)
//   Done     - one-cycle pulse in the cycle HI/LO show a new MULT/DIV result
//   HI, LO   - HI/LO registers (MFHI/MFLO read these directly)
module mdu_e #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_reg;
    logic [CW-1:0]   count_reg;
    logic [2:0]      op_reg;
    logic [31:0]     a_reg;
    logic [31:0]     b_reg;
    logic [31:0]     hi_reg;
    logic [31:0]     lo_reg;
    logic            busy_reg;
    logic            done_reg;

    // Products. The low 64 bits of a product of sign-extended operands equal
    // the signed 64-bit product, so one unsigned multiplier form serves both.
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    assign prod_s = {{32{a_reg[31]}}, a_reg} * {{32{b_reg[31]}}, b_reg};
    assign prod_u = {32'd0, a_reg} * {32'd0, b_reg};

    // Division on magnitudes, then re-apply signs. This also handles
    // 0x80000000 / -1 cleanly: quotient magnitude 0x80000000 negates to itself.
    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign div_signed = (op_reg == OP_DIV);
    assign a_neg      = div_signed & a_reg[31];
    assign b_neg      = div_signed & b_reg[31];
    assign a_mag      = a_neg ? (~a_reg + 32'd1) : a_reg;
    assign b_mag      = b_neg ? (~b_reg + 32'd1) : b_reg;
    // Divide-by-zero result is discarded at commit; substitute 1 to keep the
    // divider's output defined.
    assign divisor    = (b_reg == 32'd0) ? 32'd1 : b_mag;
    assign q_mag      = a_mag / divisor;
    assign r_mag      = a_mag % divisor;
    assign quot       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem        = a_neg ? (~r_mag + 32'd1) : r_mag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            count_reg <= '0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (Start) begin
                        case (MDUOp)
                            OP_MULT, OP_MULTU: begin
                                op_reg    <= MDUOp;
                                a_reg     <= A;
                                b_reg     <= B;
                                count_reg <= CW'(MULT_CYCLES);
                                busy_reg  <= 1'b1;
                                state_reg <= BUSY;
                            end
                            OP_DIV, OP_DIVU: begin
                                op_reg    <= MDUOp;
                                a_reg     <= A;
                                b_reg     <= B;
                                count_reg <= CW'(DIV_CYCLES);
                                busy_reg  <= 1'b1;
                                state_reg <= BUSY;
                            end
                            OP_MTHI: hi_reg <= A;
                            OP_MTLO: lo_reg <= A;
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    // Start is ignored here entirely; the D-stage stall should
                    // prevent it, but nothing is latched if it arrives anyway.
                    if (count_reg == CW'(1)) begin
                        case (op_reg)
                            OP_MULT:  {hi_reg, lo_reg} <= prod_s;
                            OP_MULTU: {hi_reg, lo_reg} <= prod_u;
                            OP_DIV, OP_DIVU: begin
                                if (b_reg != 32'd0) begin
                                    lo_reg <= quot;
                                    hi_reg <= rem;
                                end
                            end
                            default: ;
                        endcase
                        count_reg <= '0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        count_reg <= count_reg - CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign Busy = busy_reg;
    assign Done = done_reg;
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule
